sad_feeder: RTL and testbench

//  Initiator side of the SAD handshake (init/loaded/done -> out_done/ack).
//  On start: read N_GROUPS words of 4 original + 4 candidate pixels from two sync RAMs.

---
 rtl/sad_feeder.sv | 142 ++++++++++++++
 tb/tb_sad_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_feeder.sv
// sad_feeder: reads N_GROUPS groups of 4+4 pixels from two synchronous RAMs,
// presents them to the SAD block one group per 3 cycles, then runs the
// done/out_done and ack handshake and captures the SAD result.
module sad_feeder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_GROUPS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [4*WIDTH-1:0]  ori_rdata,
    input  logic [4*WIDTH-1:0]  can_rdata,
    output logic [WIDTH-1:0]    ori_0,
    output logic [WIDTH-1:0]    ori_1,
    output logic [WIDTH-1:0]    ori_2,
    output logic [WIDTH-1:0]    ori_3,
    output logic [WIDTH-1:0]    can_0,
    output logic [WIDTH-1:0]    can_1,
    output logic [WIDTH-1:0]    can_2,
    output logic [WIDTH-1:0]    can_3,
    output logic                init,
    output logic                loaded,
    output logic                done,
    output logic                ack,
    input  logic                sad_done,
    input  logic [WIDTH+4:0]    sad_in,
    output logic [WIDTH+4:0]    result,
    output logic                result_valid,
    output logic                busy
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRead,
        StFetch,
        StLoad,
        StDone,
        StAck
    } state_e;

    localparam logic [ADDR_W-1:0] LastK = ADDR_W'(N_GROUPS - 1);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      k_q, k_d;
    logic [4*WIDTH-1:0]     ori_q, can_q;
    logic [WIDTH+4:0]       result_q;
    logic                   result_valid_q;
    logic                   capture_pix;
    logic                   capture_res;

    // Next-state and handshake outputs; everything defaults to idle values.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mem_addr    = '0;
        init        = 1'b0;
        loaded      = 1'b0;
        done        = 1'b0;
        ack         = 1'b0;
        capture_pix = 1'b0;
        capture_res = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StInit;
            end
            StInit: begin
                init    = 1'b1;
                state_d = StRead;
            end
            StRead: begin
                mem_addr = k_q;
                state_d  = StFetch;
            end
            StFetch: begin
                // RAM data for the address issued in READ is valid now.
                capture_pix = 1'b1;
                state_d     = StLoad;
            end
            StLoad: begin
                loaded = 1'b1;
                if (k_q == LastK) begin
                    k_d     = '0;
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StRead;
                end
            end
            StDone: begin
                done = 1'b1;
                if (sad_done) begin
                    // ack follows sad_done from the capture cycle onwards.
                    ack         = 1'b1;
                    capture_res = 1'b1;
                    state_d     = StAck;
                end
            end
            StAck: begin
                if (sad_done) ack = 1'b1;
                else          state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, group counter, pixel and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            ori_q          <= '0;
            can_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            result_valid_q <= capture_res;
            if (capture_pix) begin
                ori_q <= ori_rdata;
                can_q <= can_rdata;
            end
            if (capture_res) result_q <= sad_in;
        end
    end

    assign ori_0        = ori_q[0*WIDTH +: WIDTH];
    assign ori_1        = ori_q[1*WIDTH +: WIDTH];
    assign ori_2        = ori_q[2*WIDTH +: WIDTH];
    assign ori_3        = ori_q[3*WIDTH +: WIDTH];
    assign can_0        = can_q[0*WIDTH +: WIDTH];
    assign can_1        = can_q[1*WIDTH +: WIDTH];
    assign can_2        = can_q[2*WIDTH +: WIDTH];
    assign can_3        = can_q[3*WIDTH +: WIDTH];
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sad_feeder.sv
// Bench for sad_feeder: RAM and ideal-SAD models, scoreboard of expected
// results, table of uniform-pixel runs plus hand-written handshake corners.
module tb_sad_feeder;
    localparam int W  = 8;
    localparam int NG = 8;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           sad_done = 1'b0;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    ori_rdata = '0, can_rdata = '0;
    logic [W-1:0]   ori_0, ori_1, ori_2, ori_3, can_0, can_1, can_2, can_3;
    logic           init, loaded, done, ack, result_valid, busy;
    logic [W+4:0]   sad_in, result;

    logic [31:0]    ori_mem [NG];
    logic [31:0]    can_mem [NG];

    int total = 0, bad = 0;
    int cyc = 0;
    int init_cnt = 0, loaded_cnt = 0, rv_cnt = 0, grp = 0;
    int last_ld = 0, first_ld_cyc = 0, done_cyc = 0, s_cyc = 0;
    logic        done_prev = 1'b0;
    logic [31:0] acc = '0;
    logic [31:0] sb [$];

    sad_feeder #(.WIDTH(W), .N_GROUPS(NG), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr),
        .ori_rdata(ori_rdata), .can_rdata(can_rdata),
        .ori_0(ori_0), .ori_1(ori_1), .ori_2(ori_2), .ori_3(ori_3),
        .can_0(can_0), .can_1(can_1), .can_2(can_2), .can_3(can_3),
        .init(init), .loaded(loaded), .done(done), .ack(ack),
        .sad_done(sad_done), .sad_in(sad_in), .result(result),
        .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs sharing one address.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ori_rdata <= ori_mem[mem_addr];
        can_rdata <= can_mem[mem_addr];
    end

    // Ideal SAD block: output is the accumulated sum over the loaded pixels.
    assign sad_in = acc[W+4:0];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? int'(a - b) : int'(b - a);
    endfunction

    function automatic logic [31:0] sad_model();
        logic [31:0] s = '0;
        for (int g = 0; g < NG; g++)
            for (int p = 0; p < 4; p++)
                s += 32'(absdiff(ori_mem[g][p*8 +: 8], can_mem[g][p*8 +: 8]));
        return s;
    endfunction

    // Monitor: pixel order/content, loaded spacing, done timing, scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            logic [31:0] o, c;
            o = {ori_3, ori_2, ori_1, ori_0};
            c = {can_3, can_2, can_1, can_0};
            if (init) begin
                init_cnt++;
                grp = 0;
                acc = '0;
            end
            if (loaded) begin
                if (grp < NG) begin
                    chk("ori_group", o, ori_mem[grp]);
                    chk("can_group", c, can_mem[grp]);
                end else begin
                    chk("extra_loaded", 32'(grp), 32'(NG - 1));
                end
                if (grp == 0) first_ld_cyc = cyc;
                else chk("loaded_gap", 32'(cyc - last_ld), 32'd3);
                chk("done_and_loaded", 32'(done), 32'd0);
                last_ld = cyc;
                for (int p = 0; p < 4; p++) acc += 32'(absdiff(o[p*8 +: 8], c[p*8 +: 8]));
                grp++;
                loaded_cnt++;
            end
            if (done && !done_prev) done_cyc = cyc;
            done_prev = done;
            if (result_valid) begin
                rv_cnt++;
                if (sb.size() == 0) chk("unexpected_result_valid", 32'd1, 32'd0);
                else chk("result", 32'(result), sb.pop_front());
            end
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic fill_uniform(input logic [7:0] o, input logic [7:0] c);
        for (int i = 0; i < NG; i++) begin
            ori_mem[i] = {4{o}};
            can_mem[i] = {4{c}};
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NG; i++) begin
            ori_mem[i] = $urandom;
            can_mem[i] = $urandom;
        end
    endtask

    // One-cycle start pulse; s_cyc is the cycle count right after the sampling edge.
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_loaded(input int n, input int ld0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (loaded && (loaded_cnt - ld0) >= n) return;
        end
        chk("loaded_timeout", 32'd0, 32'd1);
    endtask

    // Entered just after the first DONE cycle's falling edge.
    task automatic handshake(input int hold);
        int ac = 0;
        for (int i = 0; i < hold; i++) begin
            sad_done = 1'b1;
            #1;
            if (ack) ac++;
            @(negedge clk);
            #1;
        end
        sad_done = 1'b0;
        #1;
        chk("ack_drop", 32'(ack), 32'd0);
        chk("ack_cycles", 32'(ac), 32'(hold));
        @(negedge clk);
        #1;
        chk("busy_after_ack", 32'(busy), 32'd0);
    endtask

    task automatic full_run(input int hold, input logic [31:0] exp);
        int rv0, ld0;
        sb.push_back(exp);
        rv0 = rv_cnt;
        ld0 = loaded_cnt;
        launch();
        wait_done();
        chk("loaded_count", 32'(loaded_cnt - ld0), 32'(NG));
        chk("first_loaded_latency", 32'(first_ld_cyc - s_cyc), 32'd3);
        chk("done_latency", 32'(done_cyc - s_cyc), 32'(1 + 3 * NG));
        handshake(hold);
        chk("result_valid_count", 32'(rv_cnt - rv0), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  ori;
        logic [7:0]  can;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   rv0, ld0, i0;
        vecs[0] = '{ori: 8'd10,  can: 8'd7,   exp: 32'd96,   hold: 5};
        vecs[1] = '{ori: 8'd255, can: 8'd0,   exp: 32'd8160, hold: 1};
        vecs[2] = '{ori: 8'd0,   can: 8'd255, exp: 32'd8160, hold: 2};
        vecs[3] = '{ori: 8'd3,   can: 8'd3,   exp: 32'd0,    hold: 3};
        vecs[4] = '{ori: 8'd100, can: 8'd40,  exp: 32'd1920, hold: 1};
        fill_uniform(8'd0, 8'd0);

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'({init, loaded, done, ack, result_valid, busy}), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_pixels", {ori_3, ori_2, ori_1, ori_0} | {can_3, can_2, can_1, can_0}, 32'd0);

        // Table of uniform-pixel runs.
        for (int v = 0; v < 5; v++) begin
            fill_uniform(vecs[v].ori, vecs[v].can);
            full_run(vecs[v].hold, vecs[v].exp);
        end

        // sad_done pulsed during LOAD is ignored.
        fill_random();
        sb.push_back(sad_model());
        rv0 = rv_cnt;
        ld0 = loaded_cnt;
        launch();
        wait_loaded(2, ld0);
        sad_done = 1'b1;
        @(negedge clk);
        #1;
        sad_done = 1'b0;
        wait_done();
        chk("no_rv_before_done", 32'(rv_cnt - rv0), 32'd0);
        handshake(2);
        chk("rv_after_spurious", 32'(rv_cnt - rv0), 32'd1);

        // sad_done already high on DONE entry: capture on the first DONE cycle.
        fill_random();
        sb.push_back(sad_model());
        rv0 = rv_cnt;
        ld0 = loaded_cnt;
        launch();
        wait_loaded(NG - 1, ld0);
        sad_done = 1'b1;
        wait_done();
        chk("ack_on_done_entry", 32'(ack), 32'd1);
        @(negedge clk);
        #1;
        chk("rv_on_entry", 32'(rv_cnt - rv0), 32'd1);
        sad_done = 1'b0;
        @(negedge clk);
        #1;
        chk("busy_after_early", 32'(busy), 32'd0);

        // Second start pulse while busy is not queued.
        fill_random();
        i0 = init_cnt;
        sb.push_back(sad_model());
        launch();
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        handshake(1);
        repeat (3) @(negedge clk);
        #1;
        chk("single_run_inits", 32'(init_cnt - i0), 32'd1);
        chk("idle_after_single", 32'(busy), 32'd0);

        // Back-to-back runs with start held high and new RAM data in between.
        fill_random();
        i0 = init_cnt;
        rv0 = rv_cnt;
        sb.push_back(sad_model());
        @(negedge clk);
        start = 1'b1;
        wait_done();
        sad_done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        sad_done = 1'b0;
        fill_random();
        sb.push_back(sad_model());
        wait_done();
        start = 1'b0;
        handshake(3);
        chk("b2b_inits", 32'(init_cnt - i0), 32'd2);
        chk("b2b_results", 32'(rv_cnt - rv0), 32'd2);
        chk("b2b_scoreboard", 32'(sb.size()), 32'd0);

        // Asynchronous reset during the LOAD of group 3 aborts silently.
        fill_random();
        rv0 = rv_cnt;
        ld0 = loaded_cnt;
        launch();
        wait_loaded(4, ld0);
        rst = 1'b0;
        #1;
        chk("abort_ctrl", 32'({init, loaded, done, ack, result_valid, busy}), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_pixels", {ori_3, ori_2, ori_1, ori_0} | {can_3, can_2, can_1, can_0}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_after_abort", 32'(busy), 32'd0);
        chk("no_rv_after_abort", 32'(rv_cnt - rv0), 32'd0);

        // Normal run still works after the abort.
        fill_uniform(8'd20, 8'd25);
        full_run(1, 32'd160);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
